fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag stage of the async FIFO; runs entirely in the write clock domain.
- Synchronizes the read domain's Gray read pointer, advances the binary/Gray write pointer on accepted writes, and drives memory write address/enable.
- Produces full, almost-full, occupancy and overflow status toward the producer.
- Gray pointer output feeds the read-side empty logic through its synchronizer.

---
 rtl/pkg_graybin.sv | 25 ++
 rtl/sync_ff.sv | 37 +++
 rtl/fifo_wptr_full.sv | 82 ++++++++
 tb/tb_fifo_wptr_full.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_graybin.sv
// Shared Gray/binary pointer helpers and sizing constants for the async FIFO.
// Both pointer stages import this so their pointer widths always agree.
package pkg_graybin;

    localparam int DEPTH    = 8;
    localparam int DATASIZE = 8;
    localparam int ADDRW    = $clog2(DEPTH);

    // One extra MSB beyond the address distinguishes full from empty.
    typedef logic [ADDRW:0] ptr_t;

    function automatic ptr_t b2g(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t g2b(input ptr_t gray);
        ptr_t bin;
        bin[ADDRW] = gray[ADDRW];
        for (int i = ADDRW - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a Gray-coded bus entering this clock domain.
// Shared by the write-side and read-side pointer stages.
module sync_ff #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer stage of the async FIFO: advances the write pointer and
// derives full, almost-full, occupancy and sticky overflow against the synchronized read pointer.
module fifo_wptr_full
    import pkg_graybin::*;
#(
    parameter int DEPTH        = pkg_graybin::DEPTH,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  ptr_t             rptr_gray,
    output logic             wen,
    output logic [ADDRW-1:0] waddr,
    output ptr_t             wptr_gray,
    output logic             wfull,
    output logic             wafull,
    output ptr_t             wlevel,
    output logic             wovf
);

    ptr_t rq_sync;
    ptr_t rbin_s;
    ptr_t wbin_q, wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t level_q, level_d;
    logic full_q, full_d;
    logic afull_q, afull_d;
    logic ovf_q, ovf_d;
    logic acc;

    sync_ff #(
        .WIDTH       (ADDRW + 1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr_gray),
        .q     (rq_sync)
    );

    // Full means the next write pointer sits exactly DEPTH ahead of the read
    // pointer, which in Gray code is the read pointer with its top two bits inverted.
    always_comb begin
        acc     = winc & ~full_q;
        rbin_s  = g2b(rq_sync);
        wbin_d  = wbin_q + ptr_t'(acc);
        wgray_d = b2g(wbin_d);
        full_d  = (wgray_d == {~rq_sync[ADDRW:ADDRW-1], rq_sync[ADDRW-2:0]});
        level_d = wbin_d - rbin_s;
        afull_d = (int'(level_d) >= AFULL_THRESH);
        ovf_d   = ovf_q | (winc & full_q);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wen       = acc;
    assign waddr     = wbin_q[ADDRW-1:0];
    assign wptr_gray = wgray_q;
    assign wfull     = full_q;
    assign wafull    = afull_q;
    assign wlevel    = level_q;
    assign wovf      = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: a reference model pushes the expected
// snapshot for each cycle, the observed snapshot is popped and compared per scenario.
module tb_fifo_wptr_full;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;
    localparam int SYNC  = 2;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [3:0] rptr_gray;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic       wafull;
    logic [3:0] wlevel;
    logic       wovf;

    fifo_wptr_full #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .wen       (wen),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
        .wfull     (wfull),
        .wafull    (wafull),
        .wlevel    (wlevel),
        .wovf      (wovf)
    );

    always #5 wclk = ~wclk;

    // wen is the pre-edge combinational value; the rest are post-edge registers.
    typedef struct packed {
        logic       wen;
        logic [3:0] gray;
        logic [2:0] addr;
        logic [3:0] level;
        logic       full;
        logic       afull;
        logic       ovf;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];

    logic [3:0] m_bin   = '0;
    logic [3:0] m_level = '0;
    logic       m_full  = 1'b0;
    logic       m_afull = 1'b0;
    logic       m_ovf   = 1'b0;
    logic [3:0] m_sync [SYNC];
    logic [2:0] last_waddr;
    logic [3:0] r_bin;

    int errors = 0;
    int checks = 0;

    function automatic logic [3:0] tb_b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] tb_g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic drive_cycle(input logic rst_n_i, input logic winc_i, input logic [3:0] rg_i);
        snap_t e;
        snap_t o;
        logic [3:0] rb;
        logic       acc;
        wrst_n    = rst_n_i;
        winc      = winc_i;
        rptr_gray = rg_i;
        #1;
        o.wen      = wen;
        last_waddr = waddr;
        e.wen      = winc_i & ~m_full;
        if (!rst_n_i) begin
            m_bin = '0; m_level = '0; m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        end else begin
            rb      = tb_g2b(m_sync[SYNC-1]);
            acc     = winc_i & ~m_full;
            m_ovf   = m_ovf | (winc_i & m_full);
            m_bin   = m_bin + {3'b000, acc};
            m_level = m_bin - rb;
            m_full  = (m_level == 4'(DEPTH));
            m_afull = (int'(m_level) >= AFULL);
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = rg_i;
        end
        e.gray  = tb_b2g(m_bin);
        e.addr  = m_bin[2:0];
        e.level = m_level;
        e.full  = m_full;
        e.afull = m_afull;
        e.ovf   = m_ovf;
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        o.gray  = wptr_gray;
        o.addr  = waddr;
        o.level = wlevel;
        o.full  = wfull;
        o.afull = wafull;
        o.ovf   = wovf;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        snap_t e, o;
        drive_cycle(1'b0, 1'b0, 4'h0);
        drive_cycle(1'b0, 1'b0, 4'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_snapshot got=%b want=%b", o, e);
            end
        end
        checks++;
        if ({wptr_gray, waddr, wlevel, wfull, wafull, wovf} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_zero got=%b want=0", {wptr_gray, waddr, wlevel, wfull, wafull, wovf});
        end
    endtask

    task automatic test_fill();
        snap_t e, o;
        int wen_count = 0;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL fill_cycle%0d got=%b want=%b", i, o, e);
            end
            if (o.wen === 1'b1) wen_count++;
            if (i == 5) begin
                checks++;
                if (o.afull !== 1'b1 || o.level !== 4'd6 || o.full !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fill_afull6 got afull=%b level=%0d full=%b want 1/6/0", o.afull, o.level, o.full);
                end
            end
        end
        checks++;
        if (wfull !== 1'b1 || wptr_gray !== 4'b1100 || wlevel !== 4'd8) begin
            errors++;
            $display("[TB] FAIL fill_full got full=%b gray=%b level=%0d want 1/1100/8", wfull, wptr_gray, wlevel);
        end
        checks++;
        if (wen_count !== 8) begin
            errors++;
            $display("[TB] FAIL fill_wen_count got=%0d want=8", wen_count);
        end
    endtask

    task automatic test_overflow();
        snap_t e, o;
        drive_cycle(1'b1, 1'b1, 4'h0);
        drive_cycle(1'b1, 1'b1, 4'h0);
        drive_cycle(1'b1, 1'b0, 4'h0);
        drive_cycle(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL overflow_cycle%0d got=%b want=%b", i, o, e);
            end
            checks++;
            if (o.wen !== 1'b0 || o.gray !== 4'b1100 || o.ovf !== 1'b1) begin
                errors++;
                $display("[TB] FAIL overflow_hold%0d got wen=%b gray=%b ovf=%b want 0/1100/1", i, o.wen, o.gray, o.ovf);
            end
        end
    endtask

    task automatic test_read_release();
        snap_t e, o;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL release_cycle%0d got=%b want=%b", i, o, e);
            end
            checks++;
            if (i < 2 && (o.full !== 1'b1 || o.afull !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL release_linger%0d got full=%b afull=%b want 1/1", i, o.full, o.afull);
            end else if (i == 2 && (o.full !== 1'b0 || o.level !== 4'd6 || o.afull !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL release_edge3 got full=%b level=%0d afull=%b want 0/6/1", o.full, o.level, o.afull);
            end
        end
    endtask

    task automatic test_wrap();
        snap_t e, o;
        logic [3:0] prev_gray;
        logic       seen_wrap = 1'b0;
        logic       full_seen = 1'b0;
        logic [3:0] occ;
        r_bin = 4'd7;
        prev_gray = wptr_gray;
        for (int i = 0; i < 40; i++) begin
            occ = m_bin - r_bin;
            if (i % 2 == 1 && occ >= 4'd2) r_bin = r_bin + 4'd1;
            drive_cycle(1'b1, (i % 2 == 0), tb_b2g(r_bin));
        end
        for (int i = 0; i < 40; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL wrap_cycle%0d got=%b want=%b", i, o, e);
            end
            checks++;
            if ($countones(prev_gray ^ o.gray) > 1) begin
                errors++;
                $display("[TB] FAIL wrap_gray_step%0d got %b->%b want one-bit step", i, prev_gray, o.gray);
            end
            if (prev_gray == 4'b1000 && o.gray == 4'b0000) seen_wrap = 1'b1;
            if (o.full === 1'b1) full_seen = 1'b1;
            prev_gray = o.gray;
        end
        checks++;
        if (seen_wrap !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_seen got=%b want=1", seen_wrap);
        end
        checks++;
        if (full_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_no_full got=%b want=0", full_seen);
        end
    endtask

    task automatic test_reset_mid();
        snap_t e, o;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, tb_b2g(4'd13));
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, tb_b2g(4'd13));
        checks++;
        if (waddr !== 3'd5 || wovf !== 1'b1 || wfull !== 1'b1) begin
            errors++;
            $display("[TB] FAIL presetup got addr=%0d ovf=%b full=%b want 5/1/1", waddr, wovf, wfull);
        end
        drive_cycle(1'b0, 1'b0, 4'h0);
        checks++;
        if ({wptr_gray, waddr, wlevel, wfull, wafull, wovf} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL midreset_zero got=%b want=0", {wptr_gray, waddr, wlevel, wfull, wafull, wovf});
        end
        drive_cycle(1'b1, 1'b1, 4'h0);
        checks++;
        if (last_waddr !== 3'd0 || waddr !== 3'd1 || wlevel !== 4'd1) begin
            errors++;
            $display("[TB] FAIL post_reset_write got waddr=%0d->%0d level=%0d want 0->1 level 1", last_waddr, waddr, wlevel);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid_snapshot got=%b want=%b", o, e);
            end
        end
    endtask

    initial begin
        wrst_n    = 1'b0;
        winc      = 1'b0;
        rptr_gray = '0;
        for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
